// File: rtl/hex_entry_ctrl.sv
// hex_entry_ctrl: registered controller for the on-screen hex entry textbox.
// Pairs ASCII hex key presses into bytes, mirrors every accepted character
// into a display buffer read by the VGA text renderer, and queues completed
// bytes in a first-word-fall-through FIFO towards the serial transmitter.
// Optional build macro: HEX_ENTRY_BACKSPACE_EN enables backspace (8'h08),
// which discards a pending high nibble.
module hex_entry_ctrl #(
  parameter int unsigned MSG_BYTES  = 16,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned IDXW       = $clog2(2*MSG_BYTES),
  parameter int unsigned CNTW       = $clog2(MSG_BYTES+1)
) (
  input  logic            iCLK,
  input  logic            rst,
  input  logic            key_valid,
  input  logic [7:0]      key_char,
  input  logic            clr,
  input  logic            tx_ready,
  output logic            tx_valid,
  output logic [7:0]      tx_data,
  input  logic [IDXW-1:0] disp_idx,
  output logic [7:0]      disp_char,
  output logic [CNTW-1:0] byte_cnt,
  output logic            nibble_pend,
  output logic            done,
  output logic            ovf
);

  localparam int unsigned PW    = $clog2(FIFO_DEPTH);
  localparam int unsigned CW    = PW + 1;
  localparam int unsigned SLOTS = 2 * MSG_BYTES;

  typedef enum logic {
    HI = 1'b0,
    LO = 1'b1
  } state_t;

  state_t          state;
  logic [3:0]      hi_nib;
  logic [7:0]      char_buf [SLOTS];

  logic [7:0]      fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   fifo_cnt;
  logic            fifo_full;

  logic            key_hex;
  logic [3:0]      key_nib;
  logic [7:0]      key_up;
  logic            key_live;
  logic            hi_take;
  logic            lo_commit;
  logic            lo_drop;
  logic            key_bksp;
  logic            push;
  logic            pop;
  logic [IDXW-1:0] hi_slot;
  logic [IDXW-1:0] lo_slot;

  // Classify the key: hex flag, nibble value and upper-case display form.
  always_comb begin
    key_hex = 1'b0;
    key_nib = '0;
    key_up  = key_char;
    if (key_char >= 8'h30 && key_char <= 8'h39) begin
      key_hex = 1'b1;
      key_nib = key_char[3:0];
    end else if (key_char >= 8'h41 && key_char <= 8'h46) begin
      key_hex = 1'b1;
      key_nib = key_char[3:0] + 4'd9;
    end else if (key_char >= 8'h61 && key_char <= 8'h66) begin
      key_hex = 1'b1;
      key_nib = key_char[3:0] + 4'd9;
      key_up  = key_char & 8'hDF;
    end
  end

  assign done        = (byte_cnt == CNTW'(MSG_BYTES));
  assign nibble_pend = (state == LO);
  assign fifo_full   = (fifo_cnt == CW'(FIFO_DEPTH));

  // clr takes priority over any key in the same cycle; a full session ignores keys.
  assign key_live  = key_valid && !clr && !done;
  assign hi_take   = key_live && key_hex && (state == HI);
  assign lo_commit = key_live && key_hex && (state == LO) && !fifo_full;
  assign lo_drop   = key_live && key_hex && (state == LO) && fifo_full;

`ifdef HEX_ENTRY_BACKSPACE_EN
  assign key_bksp = key_live && (key_char == 8'h08) && (state == LO);
`else
  assign key_bksp = 1'b0;
`endif

  // byte_cnt < MSG_BYTES whenever a slot is written, so the doubled count fits IDXW.
  assign hi_slot = IDXW'({byte_cnt, 1'b0});
  assign lo_slot = hi_slot + IDXW'(1);

  // Fullness comes from the registered count, so a same-cycle pop never makes room.
  assign push = lo_commit;
  assign pop  = tx_valid && tx_ready;

  // Entry sequencer: nibble pairing, byte count and sticky overflow.
  always_ff @(posedge iCLK or negedge rst) begin
    if (!rst) begin
      state    <= HI;
      hi_nib   <= '0;
      byte_cnt <= '0;
      ovf      <= 1'b0;
    end else if (clr) begin
      state    <= HI;
      byte_cnt <= '0;
      ovf      <= 1'b0;
    end else begin
      if (hi_take) begin
        hi_nib <= key_nib;
        state  <= LO;
      end
      if (lo_commit) begin
        state    <= HI;
        byte_cnt <= byte_cnt + CNTW'(1);
      end
      if (lo_drop) begin
        ovf <= 1'b1;
      end
      if (key_bksp) begin
        state <= HI;
      end
    end
  end

  // Display character buffer: blank on reset/clr, one slot written per accepted key.
  always_ff @(posedge iCLK or negedge rst) begin
    if (!rst) begin
      char_buf <= '{default: 8'h20};
    end else if (clr) begin
      char_buf <= '{default: 8'h20};
    end else begin
      if (hi_take) begin
        char_buf[hi_slot] <= key_up;
      end
      if (lo_commit) begin
        char_buf[lo_slot] <= key_up;
      end
      if (key_bksp) begin
        char_buf[hi_slot] <= 8'h20;
      end
    end
  end

  // Outgoing byte FIFO; clr deliberately leaves queued bytes to drain.
  always_ff @(posedge iCLK or negedge rst) begin
    if (!rst) begin
      fifo_mem <= '{default: 8'h00};
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= {hi_nib, key_nib};
        wr_ptr           <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (push && !pop) begin
        fifo_cnt <= fifo_cnt + CW'(1);
      end else if (pop && !push) begin
        fifo_cnt <= fifo_cnt - CW'(1);
      end
    end
  end

  // Head of the FIFO falls through; an empty FIFO presents 8'h00.
  always_comb begin
    tx_valid = (fifo_cnt != '0);
    tx_data  = 8'h00;
    if (tx_valid) begin
      tx_data = fifo_mem[rd_ptr];
    end
  end

  // Combinational renderer read port; out-of-range slots read as space.
  always_comb begin
    disp_char = 8'h20;
    if ({1'b0, disp_idx} < (IDXW+1)'(SLOTS)) begin
      disp_char = char_buf[disp_idx];
    end
  end

endmodule

// File: tb/tb_hex_entry_ctrl.sv
// Self-checking bench for hex_entry_ctrl: a queue/array model of the entry
// session is compared against the DUT every cycle, with directed vectors and
// literal expectations at the interesting points.
module tb_hex_entry_ctrl;

  localparam int MSG = 16;
  localparam int DEP = 4;

  logic       iCLK = 1'b0;
  logic       rst = 1'b0;
  logic       key_valid = 1'b0;
  logic [7:0] key_char = 8'h00;
  logic       clr = 1'b0;
  logic       tx_ready = 1'b0;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic [4:0] disp_idx = 5'd0;
  logic [7:0] disp_char;
  logic [4:0] byte_cnt;
  logic       nibble_pend;
  logic       done;
  logic       ovf;

  hex_entry_ctrl #(
    .MSG_BYTES (MSG),
    .FIFO_DEPTH(DEP)
  ) dut (
    .iCLK       (iCLK),
    .rst        (rst),
    .key_valid  (key_valid),
    .key_char   (key_char),
    .clr        (clr),
    .tx_ready   (tx_ready),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .disp_idx   (disp_idx),
    .disp_char  (disp_char),
    .byte_cnt   (byte_cnt),
    .nibble_pend(nibble_pend),
    .done       (done),
    .ovf        (ovf)
  );

  always #5 iCLK = ~iCLK;

  // Model state
  logic [7:0] q[$];
  logic [7:0] m_slot [2*MSG];
  int         m_cnt;
  bit         m_lo;
  bit         m_ovf;
  logic [3:0] m_hi;
  logic [7:0] got[$];
  int         n_chk = 0;
  int         n_err = 0;
  bit         chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int hex_val(input logic [7:0] c);
    if (c >= 8'h30 && c <= 8'h39) return int'(c) - 48;
    if (c >= 8'h41 && c <= 8'h46) return int'(c) - 55;
    if (c >= 8'h61 && c <= 8'h66) return int'(c) - 87;
    return -1;
  endfunction

  function automatic logic [7:0] hex_ch(input int v, input bit lower);
    if (v < 10) return 8'(48 + v);
    return 8'((lower ? 87 : 55) + v);
  endfunction

  task automatic model_reset();
    q.delete();
    foreach (m_slot[i]) m_slot[i] = 8'h20;
    m_cnt = 0;
    m_lo  = 1'b0;
    m_ovf = 1'b0;
    m_hi  = 4'h0;
  endtask

  // Advance the model by one clock using the inputs presented before the edge.
  task automatic model_clock();
    int v;
    bit full;
    bit pop;
    full = (q.size() == DEP);
    pop  = (q.size() != 0) && tx_ready;
    v    = hex_val(key_char);
    if (clr) begin
      m_cnt = 0;
      m_lo  = 1'b0;
      m_ovf = 1'b0;
      foreach (m_slot[i]) m_slot[i] = 8'h20;
    end else if (key_valid && m_cnt < MSG) begin
      if (v >= 0) begin
        if (!m_lo) begin
          m_hi = v[3:0];
          m_slot[2*m_cnt] = hex_ch(v, 1'b0);
          m_lo = 1'b1;
        end else if (!full) begin
          m_slot[2*m_cnt+1] = hex_ch(v, 1'b0);
          q.push_back({m_hi, v[3:0]});
          m_cnt++;
          m_lo = 1'b0;
        end else begin
          m_ovf = 1'b1;
        end
      end
`ifdef HEX_ENTRY_BACKSPACE_EN
      else if (key_char == 8'h08 && m_lo) begin
        m_slot[2*m_cnt] = 8'h20;
        m_lo = 1'b0;
      end
`endif
    end
    if (pop) void'(q.pop_front());
  endtask

  // One clock: drive at the falling edge, update model after the rising edge.
  task automatic step(input bit kv, input logic [7:0] kc, input bit c, input bit rdy);
    bit fire;
    logic [7:0] d;
    key_valid = kv;
    key_char  = kc;
    clr       = c;
    tx_ready  = rdy;
    fire = tx_valid && tx_ready;
    d    = tx_data;
    @(posedge iCLK);
    model_clock();
    if (fire) got.push_back(d);
    @(negedge iCLK);
  endtask

  task automatic key(input logic [7:0] c, input bit rdy);
    step(1'b1, c, 1'b0, rdy);
  endtask

  task automatic idle(input int n, input bit rdy);
    repeat (n) step(1'b0, 8'h00, 1'b0, rdy);
  endtask

  // Per-cycle compare against the model; display slots are swept one per cycle.
  always @(negedge iCLK) begin
    if (chk_en) begin
      chk("tx_valid", tx_valid, q.size() != 0);
      if (q.size() != 0) chk("tx_data", tx_data, q[0]);
      chk("byte_cnt", byte_cnt, m_cnt);
      chk("nibble_pend", nibble_pend, m_lo);
      chk("done", done, m_cnt == MSG);
      chk("ovf", ovf, m_ovf);
      chk("disp_char", disp_char, m_slot[disp_idx]);
      disp_idx = disp_idx + 5'd1;
    end
  end

  initial begin
    model_reset();
    @(negedge iCLK);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_byte_cnt", byte_cnt, 0);
    chk("rst_nibble_pend", nibble_pend, 0);
    chk("rst_done", done, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_disp_char", disp_char, 8'h20);
    @(negedge iCLK);
    rst = 1'b1;
    chk_en = 1'b1;

    // '3','c' -> byte 3C
    key(8'h33, 1'b1);
    chk("t1_pend_after_hi", nibble_pend, 1);
    key(8'h63, 1'b1);
    chk("t1_tx_data", tx_data, 8'h3C);
    chk("t1_byte_cnt", byte_cnt, 1);
    chk("t1_pend", nibble_pend, 0);
    chk("t1_slot0", m_slot[0], 8'h33);
    chk("t1_slot1", m_slot[1], 8'h43);
    idle(1, 1'b1);
    chk("t1_xfer_cnt", got.size(), 1);
    if (got.size() == 1) chk("t1_xfer_data", got[0], 8'h3C);
    idle(34, 1'b1);

    // FIFO fill with tx_ready low, overflow on the 5th byte
    step(1'b0, 8'h00, 1'b1, 1'b0);
    key(8'h31, 1'b0); key(8'h31, 1'b0);
    key(8'h32, 1'b0); key(8'h32, 1'b0);
    key(8'h33, 1'b0); key(8'h33, 1'b0);
    key(8'h34, 1'b0); key(8'h34, 1'b0);
    key(8'h35, 1'b0); key(8'h35, 1'b0);
    chk("t2_byte_cnt", byte_cnt, 4);
    chk("t2_ovf", ovf, 1);
    chk("t2_pend", nibble_pend, 1);
    chk("t2_tx_hold", tx_data, 8'h11);
    chk("t2_slot8", m_slot[8], 8'h35);
    chk("t2_slot9", m_slot[9], 8'h20);
    idle(34, 1'b0);
    chk("t2_tx_stall", tx_data, 8'h11);
    got.delete();
    key(8'h36, 1'b1);
    chk("t2_no_push_on_pop", byte_cnt, 4);
    key(8'h36, 1'b1);
    chk("t2_byte_cnt_after", byte_cnt, 5);
    idle(6, 1'b1);
    chk("t2_xfer_cnt", got.size(), 5);
    if (got.size() == 5) begin
      chk("t2_x0", got[0], 8'h11);
      chk("t2_x1", got[1], 8'h22);
      chk("t2_x2", got[2], 8'h33);
      chk("t2_x3", got[3], 8'h44);
      chk("t2_x4", got[4], 8'h56);
    end

    // Non-hex keys in HI are ignored
    step(1'b0, 8'h00, 1'b1, 1'b1);
    key(8'h47, 1'b1);
    chk("t3_G_pend", nibble_pend, 0);
    key(8'h0D, 1'b1);
    chk("t3_cr_pend", nibble_pend, 0);
    chk("t3_cr_cnt", byte_cnt, 0);
    chk("t3_slot0", m_slot[0], 8'h20);
    key(8'h37, 1'b1);
    key(8'h30, 1'b1);
    chk("t3_tx_valid", tx_valid, 1);
    chk("t3_tx_data", tx_data, 8'h70);

    // Full message, done, ignored 17th key, clr
    step(1'b0, 8'h00, 1'b1, 1'b1);
    got.delete();
    for (int i = 0; i < MSG; i++) begin
      key(hex_ch(i, 1'b0), 1'b1);
      key(hex_ch(15 - i, (i % 2) == 1), 1'b1);
    end
    chk("t4_done", done, 1);
    chk("t4_byte_cnt", byte_cnt, 16);
    key(8'h39, 1'b1);
    chk("t4_17th_pend", nibble_pend, 0);
    chk("t4_17th_cnt", byte_cnt, 16);
    idle(2, 1'b1);
    chk("t4_xfer_cnt", got.size(), MSG);
    if (got.size() == MSG) begin
      for (int i = 0; i < MSG; i++) begin
        chk("t4_xfer", got[i], {i[3:0], 4'(15 - i)});
      end
    end
    chk("t4_slot31", m_slot[31], 8'h30);
    idle(34, 1'b1);
    step(1'b0, 8'h00, 1'b1, 1'b1);
    chk("t4_clr_done", done, 0);
    chk("t4_clr_cnt", byte_cnt, 0);
    idle(34, 1'b1);

    // clr beats a same-cycle key; async reset empties a stalled FIFO
    step(1'b1, 8'h35, 1'b1, 1'b1);
    chk("t5_pend", nibble_pend, 0);
    chk("t5_slot0", m_slot[0], 8'h20);
    key(8'h61, 1'b0);
    key(8'h62, 1'b0);
    chk("t5_tx_valid", tx_valid, 1);
    chk("t5_tx_data", tx_data, 8'hAB);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    chk("t5_rst_tx_valid", tx_valid, 0);
    chk("t5_rst_tx_data", tx_data, 8'h00);
    chk("t5_rst_cnt", byte_cnt, 0);
    @(negedge iCLK);
    rst = 1'b1;
    idle(2, 1'b0);

    // Backspace handling (build dependent)
    step(1'b0, 8'h00, 1'b1, 1'b0);
    key(8'h41, 1'b0);
    key(8'h08, 1'b0);
`ifdef HEX_ENTRY_BACKSPACE_EN
    chk("t6_bs_pend", nibble_pend, 0);
    key(8'h42, 1'b0);
    key(8'h31, 1'b0);
    chk("t6_tx_data", tx_data, 8'hB1);
    chk("t6_slot0", m_slot[0], 8'h42);
`else
    chk("t6_bs_pend", nibble_pend, 1);
    key(8'h42, 1'b0);
    key(8'h31, 1'b0);
    chk("t6_tx_data", tx_data, 8'hAB);
    chk("t6_slot0", m_slot[0], 8'h41);
`endif
    idle(34, 1'b1);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/hex_entry_ctrl.md
Name: hex_entry_ctrl

Overview:
Sequencer for the on-screen hex entry textbox. It takes ASCII key presses and pairs hex nibbles into bytes. Each entered character goes into a display character buffer that the VGA text renderer reads, and each completed byte is pushed through a small FIFO to the serial transmitter over a valid/ready handshake. This replaces the combinational press-count decode with a registered controller.

Parameters:
MSG_BYTES, 16, bytes per message; entry stops at this count.
FIFO_DEPTH, 4, depth of the outgoing byte FIFO; must be a power of 2, at least 2.
IDXW, $clog2(2*MSG_BYTES), display index width (derived).
CNTW, $clog2(MSG_BYTES+1), byte counter width (derived).

Ports:
iCLK  in  1  system clock; all logic is rising-edge.
rst  in  1  asynchronous, active-low reset.
key_valid  in  1  single-cycle strobe; key_char is valid this cycle.
key_char  in  8  ASCII code of the pressed key.
clr  in  1  synchronous clear of the entry session.
tx_ready  in  1  transmitter accepts tx_data this cycle.
tx_valid  out  1  FIFO head is valid.
tx_data  out  8  FIFO head byte.
disp_idx  in  IDXW  character slot requested by the renderer.
disp_char  out  8  ASCII at disp_idx; combinational read; 8'h20 if disp_idx >= 2*MSG_BYTES.
byte_cnt  out  CNTW  number of bytes committed.
nibble_pend  out  1  a high nibble is held and waiting for its low nibble.
done  out  1  byte_cnt == MSG_BYTES.
ovf  out  1  sticky flag: a byte was lost because the FIFO was full.

Behaviour:
- Reset (rst low, asynchronous):
  - state HI; byte_cnt 0; nibble_pend 0; done 0; ovf 0.
  - All buffer slots 8'h20; FIFO empty; tx_valid 0; tx_data 8'h00.
- Key decode:
  - '0'-'9', 'A'-'F' and 'a'-'f' are hex. Lower case is stored upper case in the buffer.
  - Any other key is ignored with no state change (except backspace under the optional feature).
- FSM state HI, on a hex key while not done:
  - hold the nibble in the hi register;
  - write the char to slot 2*byte_cnt;
  - go to LO; nibble_pend becomes 1.
- FSM state LO, on a hex key:
  - If the FIFO is not full: write the char to slot 2*byte_cnt+1, push {hi, lo} to the FIFO, increment byte_cnt, go to HI, clear nibble_pend.
  - If the FIFO is full: drop the key, set ovf, stay in LO. The buffer is unchanged.
- Full detection uses the registered FIFO count at the start of the cycle. A pop in the same cycle does not free space for a push in that cycle.
- done: once byte_cnt reaches MSG_BYTES, done is 1 and all keys are ignored until clr.
- Latency:
  - A committing key at edge N gives tx_valid=1 after edge N when the FIFO was empty.
  - disp_char reflects a write one cycle after the key strobe.
- FIFO handshake:
  - A pop occurs on a cycle with tx_valid && tx_ready.
  - tx_data and tx_valid are stable while tx_valid && !tx_ready.
  - First-word-fall-through: tx_data equals the head whenever tx_valid is 1.
- clr behaviour:
  - Returns to HI, clears byte_cnt, nibble_pend, done and ovf, and sets all slots to 8'h20.
  - The FIFO is not flushed; queued bytes still drain.
  - clr and key_valid in the same cycle: clr wins and the key is discarded.
- Reset mid-transfer: reset asserted while tx_valid && !tx_ready empties the FIFO immediately.
- Pointer wrap: FIFO read and write pointers wrap modulo FIFO_DEPTH, and count uses one extra bit.

Optional Feature:
- Macro: HEX_ENTRY_BACKSPACE_EN.
- When defined, key 8'h08 in state LO:
  - sets slot 2*byte_cnt to 8'h20;
  - returns to HI and clears nibble_pend.
- Backspace in HI, or when done, is ignored; committed bytes are never undone.
- When not defined, 8'h08 is treated like any other non-hex key and ignored.

Test Plan:
- Keys '3','c' with tx_ready=1 -> slot0='3', slot1='C', one transfer with tx_data=8'h3C, byte_cnt=1, nibble_pend=0.
- tx_ready=0, then keys for 5 bytes (11,22,33,44,55) -> FIFO holds 11..44, ovf=1, state LO, slot9=8'h20, byte_cnt=4. Then tx_ready=1 -> 11,22,33,44 delivered in order.
- Key 'G', then key 8'h0D, in HI -> no change. Then '7','0' -> tx_data=8'h70.
- Enter MSG_BYTES=16 bytes -> done=1. A 17th key is ignored. clr -> all slots 8'h20, byte_cnt=0, done=0.
- clr and key '5' in the same cycle -> slot0 stays 8'h20 and state is HI. rst low while tx_valid=1 -> tx_valid=0 immediately.
- With HEX_ENTRY_BACKSPACE_EN: 'A', 8'h08, 'B', '1' -> tx_data=8'hB1, slot0='B'.
